// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller:
//   - StallBus vector type and the Stop/NoStop bit levels
//   - stall pattern constants for each requester (MEM, DIV, ID, none)
//   - divider sequencer state encoding and counter width
//   - sat_inc32: saturating 32-bit increment used by the perf counters
//     (which exist only when CTRL_PERF_EN is defined)
package pipeline_ctrl_pkg;

  // Bit i freezes stage i: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  typedef logic [5:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam StallBus CTRL_STALL_MEM  = 6'b011111;
  localparam StallBus CTRL_STALL_DIV  = 6'b001111;
  localparam StallBus CTRL_STALL_ID   = 6'b000111;
  localparam StallBus CTRL_STALL_NONE = 6'b000000;

  localparam int STAGE_EX = 3;

  // Wide enough for DIV_CYCLES-2 with DIV_CYCLES up to 63.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_HOLD = 2'd2
  } div_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ctrl_div_seq.sv
// ctrl_div_seq
//   Divider busy-window sequencer. Counts the EX stall window of a
//   multi-cycle divide, then holds div_done until EX is free to advance.
//
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     div_start   a divide sits in EX (only sampled in IDLE)
//     flush       pipeline flush; aborts the divide, suppresses div_done
//     ex_stop     EX is frozen by another requester (MEM) this cycle
//     div_stall   apply the DIV stall pattern this cycle
//     div_done    divider result valid in EX
//     state       current FSM state (debug visibility)
module ctrl_div_seq
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_start,
  input  logic       flush,
  input  logic       ex_stop,
  output logic       div_stall,
  output logic       div_done,
  output div_state_e state
);

  // Start cycle stalls in IDLE, so BUSY covers the remaining
  // DIV_CYCLES-1 cycles: cnt counts DIV_CYCLES-2 down to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  div_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_stall = 1'b0;
    div_done  = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (div_start) begin
          div_stall = 1'b1;
          state_nxt = DIV_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      DIV_BUSY: begin
        div_stall = 1'b1;
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else           state_nxt = DIV_HOLD;
      end
      DIV_HOLD: begin
        div_done = 1'b1;
        if (!ex_stop) state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
    // A flush kills the instruction in EX: no result is delivered and a
    // simultaneous start in IDLE is dropped.
    if (flush) begin
      state_nxt = DIV_IDLE;
      cnt_nxt   = cnt;
      div_done  = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Merges the
//   ID load-use, EX divider and MEM SRAM-wait stall requests into the
//   shared StallBus and converts exceptions into a one-cycle flush.
//
//   Parameter:
//     DIV_CYCLES   EX stall cycles per divide (2..63)
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     stallreq_id    ID load-use hazard (level)
//     div_start      divide present in EX (level)
//     stallreq_mem   data SRAM not ready (level)
//     excp_valid     exception / eret in MEM
//     excp_pc        redirect target
//     stall          per-stage freeze vector (1 = Stop)
//     div_done       divider result valid in EX
//     flush          clear all stage registers
//     new_pc         redirect PC, valid while flush=1 (0 otherwise)
//     perf_bus       {id_cnt, div_cnt, mem_cnt}; only with CTRL_PERF_EN
//
//   Build option: define CTRL_PERF_EN to add the saturating stall-cycle
//   counters and the perf_bus port.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  output StallBus     stall,
  output logic        div_done,
  output logic        flush,
  output logic [31:0] new_pc
`ifdef CTRL_PERF_EN
  ,
  output logic [95:0] perf_bus
`endif
);

  StallBus    pat_mem;
  StallBus    pat_div;
  StallBus    pat_id;
  logic       div_stall;
  div_state_e div_state;

  // Only MEM can hold EX while the divider waits in HOLD: the DIV pattern
  // is already removed there and the ID pattern never covers EX, so the
  // MEM pattern's EX bit is the post-merge stall[3] without a comb loop.
  ctrl_div_seq #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_seq (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .flush     (excp_valid),
    .ex_stop   (pat_mem[STAGE_EX] == Stop),
    .div_stall (div_stall),
    .div_done  (div_done),
    .state     (div_state)
  );

  always_comb begin
    pat_mem = stallreq_mem ? CTRL_STALL_MEM : CTRL_STALL_NONE;
    pat_div = div_stall    ? CTRL_STALL_DIV : CTRL_STALL_NONE;
    pat_id  = stallreq_id  ? CTRL_STALL_ID  : CTRL_STALL_NONE;
    stall   = CTRL_STALL_NONE;
    flush   = 1'b0;
    new_pc  = 32'd0;
    // Flush dominates: frozen stages would otherwise keep wrong-path state.
    if (excp_valid) begin
      flush  = 1'b1;
      new_pc = excp_pc;
    end else begin
      stall = pat_mem | pat_div | pat_id;
    end
  end

`ifdef CTRL_PERF_EN
  logic [31:0] id_cnt;
  logic [31:0] div_cnt;
  logic [31:0] mem_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_cnt  <= 32'd0;
      div_cnt <= 32'd0;
      mem_cnt <= 32'd0;
    end else if (!excp_valid) begin
      if (stallreq_id)  id_cnt  <= sat_inc32(id_cnt);
      if (div_stall)    div_cnt <= sat_inc32(div_cnt);
      if (stallreq_mem) mem_cnt <= sat_inc32(mem_cnt);
    end
  end

  assign perf_bus = {id_cnt, div_cnt, mem_cnt};
`endif

  // State is observable for debug probes; this keeps it referenced.
  logic div_idle;
  assign div_idle = (div_state == DIV_IDLE);
  logic unused_ok;
  assign unused_ok = div_idle;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Scoreboard bench for pipeline_ctrl. A behavioural model tracks the
//   divide by its start cycle (stall while elapsed < DIV_CYCLES, result
//   pending afterwards until a cycle without MEM stall) and pushes the
//   expected outputs of every cycle into exp_q; a negedge monitor pops and
//   compares. Define CTRL_PERF_EN to also check perf_bus.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int N = 32;
`ifdef CTRL_PERF_EN
  localparam int W = 41 + 96;
`else
  localparam int W = 41;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        div_start;
  logic        stallreq_mem;
  logic        excp_valid;
  logic [31:0] excp_pc;
  StallBus     stall;
  logic        div_done;
  logic        flush;
  logic [31:0] new_pc;
`ifdef CTRL_PERF_EN
  logic [95:0] perf_bus;
`endif

  pipeline_ctrl #(.DIV_CYCLES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .div_start    (div_start),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_pc      (excp_pc),
    .stall        (stall),
    .div_done     (div_done),
    .flush        (flush),
    .new_pc       (new_pc)
`ifdef CTRL_PERF_EN
    ,
    .perf_bus     (perf_bus)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit m_known = 0;   // model state valid once a reset edge has been seen
  bit m_run = 0;     // a divide is in flight (stalling or waiting to retire)
  int m_start = 0;   // cycle the divide began
  logic [31:0] m_id, m_div, m_mem;

  function automatic logic [31:0] sat(input logic [31:0] v, input logic inc);
    if (!inc || v == 32'hFFFF_FFFF) return v;
    return v + 32'd1;
  endfunction

  task automatic drive(input logic r, input logic id, input logic ds,
                       input logic mem, input logic ex, input logic [31:0] pc);
    logic       dstall;
    logic       ddone;
    logic [5:0] est;
    logic [W-1:0] pkt;
    int el;
    rst = r; stallreq_id = id; div_start = ds; stallreq_mem = mem;
    excp_valid = ex; excp_pc = pc;
    el = cyc - m_start;
    dstall = m_run ? (el < N) : ds;
    ddone  = m_run && (el >= N) && !ex;
    est = 6'b000000;
    if (!ex) begin
      if (mem)    est = est | 6'b011111;
      if (dstall) est = est | 6'b001111;
      if (id)     est = est | 6'b000111;
    end
`ifdef CTRL_PERF_EN
    pkt = {est, ddone, ex, (ex ? pc : 32'd0), !m_run, m_id, m_div, m_mem};
`else
    pkt = {est, ddone, ex, (ex ? pc : 32'd0), !m_run};
`endif
    if (m_known) exp_q.push_back(pkt);
    // advance model to the next cycle
    if (r) begin
      m_known = 1; m_run = 0;
      m_id = 0; m_div = 0; m_mem = 0;
    end else begin
      if (!ex) begin
        m_id  = sat(m_id, id);
        m_div = sat(m_div, dstall);
        m_mem = sat(m_mem, mem);
      end
      if (ex)                            m_run = 0;
      else if (!m_run && ds)             begin m_run = 1; m_start = cyc; end
      else if (m_run && el >= N && !mem) m_run = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle~%0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("stall",    96'(stall),    96'(e[W-1 -: 6]));
      chk("div_done", 96'(div_done), 96'(e[W-7]));
      chk("flush",    96'(flush),    96'(e[W-8]));
      chk("new_pc",   96'(new_pc),   96'(e[W-9 -: 32]));
      chk("idle",     96'(dut.u_div_seq.state == DIV_IDLE), 96'(e[W-41]));
`ifdef CTRL_PERF_EN
      chk("perf_bus", perf_bus, e[95:0]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; stallreq_id = 0; div_start = 0; stallreq_mem = 0;
    excp_valid = 0; excp_pc = 0;
    m_id = 0; m_div = 0; m_mem = 0;
    @(posedge clk); #1;
    // reset 3 cycles, then idle
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0);
    // 5 ID stall cycles plus one full divide (perf scenario)
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N + 1; i++) drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
    // single-cycle ID stall
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // divide with MEM stall straddling its end (rel. cycles 30..34)
    for (int i = 0; i < N + 6; i++)
      drive(0, 0, 1, (i >= 30 && i <= 34), 0, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0);
    // back-to-back divides: div_start held across HOLD->IDLE
    for (int i = 0; i < 2 * N + 4; i++) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // flush mid-divide
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 32'hBFC0_0380);
    for (int i = 0; i < N + 4; i++) drive(0, 0, 0, 0, 0, 0);
    // flush and div_start together in IDLE
    drive(0, 1, 1, 1, 1, 32'h1234_5678);
    drive(0, 0, 0, 0, 0, 0);
    // reset mid-divide
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic id, ds, mem, ex;
      id  = ($urandom_range(0, 99) < 20);
      ds  = ($urandom_range(0, 99) < 40);
      mem = ($urandom_range(0, 99) < 20);
      ex  = ($urandom_range(0, 99) < 2);
      drive(0, id, ds, mem, ex, $urandom);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d entries left required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline. It merges stall requests from ID (load-use), EX (multi-cycle divider) and MEM (data SRAM not ready) into the shared `StallBus` vector consumed by every stage register (PC, IF, ID, EX, MEM, WB). It sequences the divider's busy window with an internal counter, holds the divider result until EX may advance, and turns exception requests into a single-cycle flush with a redirect PC.

## Interface
Parameters:
- DIV_CYCLES, 32: EX stall cycles per divide, counted from the start cycle; legal range 2..63.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- stallreq_id  in  1  ID load-use hazard request, level.
- div_start  in  1  EX holds a divide this cycle, level while the divide sits in EX.
- stallreq_mem  in  1  data SRAM not ready, level.
- excp_valid  in  1  exception or eret in MEM this cycle.
- excp_pc  in  32  redirect target.
- stall  out  `StallBus` (6)  bit i = `Stop` freezes stage i (0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
- div_done  out  1  divider result valid in EX.
- flush  out  1  clear all stage registers.
- new_pc  out  32  PC redirect, valid when flush=1.
- perf_bus  out  96  {id_cnt, div_cnt, mem_cnt}. Present only with CTRL_PERF_EN.

## Operation
- Stall patterns (`Stop`=1):
  - MEM 6'b011111
  - DIV 6'b001111
  - ID 6'b000111
  - none 6'b000000
- stall is the bitwise OR of the active patterns. With a stall at bit k and none at bit k+1, stage k+1 receives a bubble. The stage registers implement this.
- Priority: flush dominates. When excp_valid=1: stall=0, flush=1, new_pc=excp_pc, and the divider FSM returns to IDLE.
- Divider FSM states: IDLE, BUSY, HOLD.
  - IDLE: div_start=1 applies the DIV pattern this cycle, loads cnt←DIV_CYCLES-2, and moves to BUSY.
  - BUSY: applies the DIV pattern. If cnt≠0, decrements cnt. If cnt=0, moves to HOLD.
  - HOLD: div_done=1 and the DIV pattern is removed. If stall[3] is `NoStop` after the merge (no MEM stall), returns to IDLE. Otherwise stays in HOLD with div_done held.
  - The counter keeps running during a MEM stall.
- div_start is ignored outside IDLE.
- div_start in the cycle after HOLD→IDLE starts a new divide, because a new instruction can enter EX back-to-back.
- cnt width is 6 bits. No wrap-around is possible because cnt is only loaded in IDLE.

## Timing
- Reset values: stall=0, div_done=0, flush=0, new_pc=0, state IDLE, cnt=0, perf counters 0.
- stall, flush and new_pc are combinational from the inputs and state, with zero-cycle latency. Only state, cnt and the perf counters are registered.
- Divide started at cycle T: DIV pattern over T..T+DIV_CYCLES-1. div_done first asserts at T+DIV_CYCLES and remains until the first cycle with no MEM stall.
- Reset in mid-divide forces IDLE on the next edge. Flush in mid-divide does the same and no div_done is issued.
- Simultaneous excp_valid and div_start in IDLE: flush wins and the FSM stays IDLE.

## Configuration
- CTRL_PERF_EN defined:
  - Three 32-bit saturating counters increment each cycle the ID, DIV or MEM pattern is active. Counting is independent; multiple counters can increment in the same cycle.
  - Counters do not increment in flush cycles.
  - Counters clear only on rst.
  - perf_bus is driven.
- CTRL_PERF_EN undefined: counters and the perf_bus port are absent. All other behaviour is identical.

## Structure
- Add to the shared defines header (alongside `StallBus`, `Stop`, `NoStop`):
  - CTRL_STALL_MEM, CTRL_STALL_DIV, CTRL_STALL_ID, CTRL_STALL_NONE pattern constants.
  - The divider FSM state encodings.
- One sub-module, ctrl_div_seq, holds the IDLE/BUSY/HOLD FSM and the counter. Its outputs are div_stall and div_done.
- Pattern merging, flush and perf counters live in pipeline_ctrl.

## Test plan
- rst held 3 cycles, then released with all requests 0 → stall=0, flush=0, div_done=0.
- stallreq_id=1 for one cycle → stall=6'b000111 in that cycle only; 6'b000000 the next.
- DIV_CYCLES=32, div_start held from cycle 10 → stall=6'b001111 on cycles 10..41; div_done=1 on cycle 42; IDLE on 43.
- Same divide with stallreq_mem=1 on cycles 40..44:
  - stall=6'b011111 on cycles 40..44.
  - div_done high on cycles 42..45.
  - Return to IDLE after cycle 45.
- excp_valid=1, excp_pc=32'hBFC0_0380 on cycle 20 of a divide → flush=1, new_pc=32'hBFC0_0380, stall=0 that cycle; IDLE on 21; no div_done.
- CTRL_PERF_EN, 5 ID-stall cycles plus one 32-cycle divide → perf_bus={32'd5, 32'd32, 32'd0}.
